// File: rtl/paint_canvas_ctrl_if.sv
// Port bundle between the display/cursor side and the frame-buffer controller.
// master drives video, cursor and clear controls; slave owns the RAM port and status.
interface paint_canvas_ctrl_if #(
    parameter int ADDR_W   = 15,
    parameter int COLOUR_W = 12,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int BRUSH_W  = 2
);
    logic                screen_on;
    logic [ADDR_W-1:0]   disp_addr;
    logic [X_W-1:0]      cursor_x;
    logic [Y_W-1:0]      cursor_y;
    logic [COLOUR_W-1:0] draw_colour;
    logic                draw_en;
    logic [BRUSH_W-1:0]  brush_size;
    logic                clear_req;
    logic [COLOUR_W-1:0] clear_colour;
    logic [ADDR_W-1:0]   ram_a;
    logic                ram_we;
    logic [COLOUR_W-1:0] ram_wd;
    logic                busy;
    logic                clear_done;

    modport master (
        output screen_on, disp_addr, cursor_x, cursor_y, draw_colour, draw_en,
               brush_size, clear_req, clear_colour,
        input  ram_a, ram_we, ram_wd, busy, clear_done
    );

    modport slave (
        input  screen_on, disp_addr, cursor_x, cursor_y, draw_colour, draw_en,
               brush_size, clear_req, clear_colour,
        output ram_a, ram_we, ram_wd, busy, clear_done
    );
endinterface

// File: rtl/paint_canvas_ctrl.sv
// Frame-buffer port mux plus brush-stamp / clear engine; display address is combinational, engine writes one pixel per blanking cycle.
// Active video stalls the engine in place (no writes, no progress); it resumes on the first blanking cycle.
module paint_canvas_ctrl #(
    parameter int H_RES     = 160,
    parameter int V_RES     = 120,
    parameter int ADDR_W    = 15,
    parameter int COLOUR_W  = 12,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int MAX_BRUSH = 4,
    parameter int BRUSH_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    paint_canvas_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [BRUSH_W-1:0] SIZE_MAX  = BRUSH_W'(MAX_BRUSH - 1);

    typedef enum logic [1:0] {IDLE, BRUSH, CLEAR} state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
        logic [BRUSH_W-1:0]  size;
    } stamp_t;

    state_t              state, state_nxt;
    stamp_t              cur, cur_nxt;
    stamp_t              last, last_nxt;
    stamp_t              req;
    logic                stamp_valid, stamp_valid_nxt;
    logic                clear_pending, clear_pending_nxt;
    logic                done_q, done_nxt;
    logic [BRUSH_W-1:0]  dx, dx_nxt, dy, dy_nxt;
    logic [ADDR_W-1:0]   clr_addr, clr_addr_nxt;
    logic [BRUSH_W-1:0]  size_sat;
    logic [X_W:0]        px;
    logic [Y_W:0]        py;
    logic                clipped;
    logic [ADDR_W-1:0]   eng_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cur           <= '0;
            last          <= '0;
            stamp_valid   <= 1'b0;
            clear_pending <= 1'b0;
            done_q        <= 1'b0;
            dx            <= '0;
            dy            <= '0;
            clr_addr      <= '0;
        end else begin
            state         <= state_nxt;
            cur           <= cur_nxt;
            last          <= last_nxt;
            stamp_valid   <= stamp_valid_nxt;
            clear_pending <= clear_pending_nxt;
            done_q        <= done_nxt;
            dx            <= dx_nxt;
            dy            <= dy_nxt;
            clr_addr      <= clr_addr_nxt;
        end
    end

    always_comb begin
        size_sat = (bus.brush_size > SIZE_MAX) ? SIZE_MAX : bus.brush_size;
        req      = '{x: bus.cursor_x, y: bus.cursor_y, colour: bus.draw_colour, size: size_sat};

        // One extra bit on each axis so a brush hanging off the edge clips instead of wrapping.
        px       = {1'b0, cur.x} + (X_W+1)'(dx);
        py       = {1'b0, cur.y} + (Y_W+1)'(dy);
        clipped  = (state == BRUSH) && ((32'(px) >= H_RES) || (32'(py) >= V_RES));

        unique case (state)
            BRUSH:   eng_addr = ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px);
            CLEAR:   eng_addr = clr_addr;
            default: eng_addr = '0;
        endcase

        state_nxt         = state;
        cur_nxt           = cur;
        last_nxt          = last;
        stamp_valid_nxt   = stamp_valid;
        clear_pending_nxt = clear_pending;
        done_nxt          = 1'b0;
        dx_nxt            = dx;
        dy_nxt            = dy;
        clr_addr_nxt      = clr_addr;

        // A request arriving while busy stamping or during video is remembered, never dropped.
        if (bus.clear_req && state != CLEAR) clear_pending_nxt = 1'b1;

        if (!bus.screen_on) begin
            unique case (state)
                IDLE: begin
                    if (bus.clear_req || clear_pending) begin
                        state_nxt         = CLEAR;
                        cur_nxt.colour    = bus.clear_colour;
                        clr_addr_nxt      = '0;
                        clear_pending_nxt = 1'b0;
                    end else if (bus.draw_en && (!stamp_valid || req != last)) begin
                        state_nxt = BRUSH;
                        cur_nxt   = req;
                        dx_nxt    = '0;
                        dy_nxt    = '0;
                    end
                end
                BRUSH: begin
                    if (dx == cur.size) begin
                        dx_nxt = '0;
                        if (dy == cur.size) begin
                            state_nxt       = IDLE;
                            stamp_valid_nxt = 1'b1;
                            last_nxt        = cur;
                        end else begin
                            dy_nxt = dy + 1'b1;
                        end
                    end else begin
                        dx_nxt = dx + 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state_nxt       = IDLE;
                        done_nxt        = 1'b1;
                        stamp_valid_nxt = 1'b0;
                    end else begin
                        clr_addr_nxt = clr_addr + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.ram_a      = bus.screen_on ? bus.disp_addr : eng_addr;
    assign bus.ram_we     = !bus.screen_on && (state != IDLE) && !clipped && !reset;
    assign bus.ram_wd     = (state == IDLE) ? '0 : cur.colour;
    assign bus.busy       = (state != IDLE);
    assign bus.clear_done = done_q;
endmodule

// File: tb/tb_paint_canvas_ctrl.sv
// Bench for paint_canvas_ctrl: directed and randomized stamps, clears, pause and reset scenarios.
module tb_paint_canvas_ctrl;
    localparam int H_RES = 160, V_RES = 120, ADDR_W = 15, COLOUR_W = 12;
    localparam int X_W = 8, Y_W = 7, MAX_BRUSH = 4, BRUSH_W = 2;
    localparam int PIX = H_RES * V_RES;

    logic clk = 1'b0;
    logic reset;
    int   vec = 0;
    int   err = 0;

    // Last completed stamp as the bench understands it.
    bit m_valid = 1'b0;
    int m_x, m_y, m_col, m_size;

    paint_canvas_ctrl_if #(.ADDR_W(ADDR_W), .COLOUR_W(COLOUR_W), .X_W(X_W), .Y_W(Y_W),
                           .BRUSH_W(BRUSH_W)) bus ();

    paint_canvas_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .COLOUR_W(COLOUR_W),
                        .X_W(X_W), .Y_W(Y_W), .MAX_BRUSH(MAX_BRUSH), .BRUSH_W(BRUSH_W))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        bus.screen_on = 1'b0;  bus.disp_addr = '0;
        bus.cursor_x = '0;     bus.cursor_y = '0;   bus.draw_colour = '0;
        bus.draw_en = 1'b1;    bus.brush_size = '0;
        bus.clear_req = 1'b0;  bus.clear_colour = '0;
        repeat (3) begin
            @(negedge clk);
            vec++;
            if (bus.ram_we !== 1'b0) begin err++; $display("FAIL reset_we: ram_we=%b expected 0", bus.ram_we); end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.draw_en = 1'b0;
        @(negedge clk);
        vec++;
        if (bus.busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.ram_we !== 1'b0) begin
            err++; $display("FAIL reset_state: busy=%b done=%b we=%b expected 0 0 0", bus.busy, bus.clear_done, bus.ram_we);
        end
        vec++;
        if (bus.ram_a !== '0 || bus.ram_wd !== '0) begin
            err++; $display("FAIL reset_idle_port: a=%0d wd=%0h expected 0 0", bus.ram_a, bus.ram_wd);
        end
        bus.disp_addr = ADDR_W'($urandom_range(1, 32767));
        bus.screen_on = 1'b1;
        #1;
        vec++;
        if (bus.ram_a !== bus.disp_addr) begin
            err++; $display("FAIL display_mux: ram_a=%0d expected %0d", bus.ram_a, bus.disp_addr);
        end
        bus.screen_on = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic test_stamp(input int cx, input int cy, input int col, input int sz,
                              input int pause_at, input int pause_len, input bit scramble);
        int s, eng;
        int exp_a[$];
        int obs_a[$];
        int obs_d[$];
        bit trig, started, paused, done;
        s = ((sz > MAX_BRUSH - 1) ? MAX_BRUSH - 1 : sz) + 1;
        trig = !m_valid || cx != m_x || cy != m_y || col != m_col || (s - 1) != m_size;
        for (int dy = 0; dy < s; dy++)
            for (int dx = 0; dx < s; dx++)
                if (cx + dx < H_RES && cy + dy < V_RES) exp_a.push_back((cy + dy) * H_RES + cx + dx);
        if (pause_at >= exp_a.size()) pause_at = -1;
        if (pause_at >= 0) scramble = 1'b0;

        @(posedge clk); #1;
        bus.screen_on = 1'b0;
        bus.cursor_x = X_W'(cx);  bus.cursor_y = Y_W'(cy);
        bus.draw_colour = COLOUR_W'(col);  bus.brush_size = BRUSH_W'(sz);
        bus.draw_en = 1'b1;

        if (!trig) begin
            repeat (4) begin
                @(negedge clk);
                vec++;
                if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0) begin
                    err++; $display("FAIL same_stamp_idle: busy=%b we=%b expected 0 0", bus.busy, bus.ram_we);
                end
            end
        end else begin
            eng = 0; started = 0; paused = 0; done = 0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (bus.busy && !bus.screen_on) begin
                    eng++;
                    if (bus.ram_we) begin obs_a.push_back(int'(bus.ram_a)); obs_d.push_back(int'(bus.ram_wd)); end
                end
                if (bus.busy) begin
                    if (!started && scramble) begin
                        @(posedge clk); #1;
                        bus.draw_en = 1'b0;
                        bus.cursor_x = X_W'($urandom);  bus.cursor_y = Y_W'($urandom);
                        bus.draw_colour = COLOUR_W'($urandom);  bus.brush_size = BRUSH_W'($urandom);
                    end
                    started = 1;
                end else if (started) begin
                    done = 1;
                    break;
                end
                if (started && !paused && pause_at >= 0 && obs_a.size() == pause_at) begin
                    paused = 1;
                    repeat (pause_len) begin
                        @(posedge clk); #1;
                        bus.screen_on = 1'b1;
                        bus.disp_addr = ADDR_W'($urandom_range(0, 32767));
                        @(negedge clk);
                        vec++;
                        if (bus.ram_we !== 1'b0 || bus.ram_a !== bus.disp_addr || bus.busy !== 1'b1) begin
                            err++; $display("FAIL pause_hold: we=%b a=%0d busy=%b expected 0 %0d 1",
                                            bus.ram_we, bus.ram_a, bus.busy, bus.disp_addr);
                        end
                    end
                    @(posedge clk); #1;
                    bus.screen_on = 1'b0;
                end
            end
            vec++;
            if (!done) begin err++; $display("FAIL stamp_timeout: engine never returned idle, expected done"); end
            vec++;
            if (eng != s * s) begin err++; $display("FAIL stamp_cycles: %0d engine cycles expected %0d", eng, s * s); end
            vec++;
            if (obs_a.size() != exp_a.size()) begin
                err++; $display("FAIL stamp_count: %0d writes expected %0d", obs_a.size(), exp_a.size());
            end
            for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
                vec++;
                if (obs_a[i] != exp_a[i] || obs_d[i] != col) begin
                    err++; $display("FAIL stamp_write[%0d]: addr %0d data %0h expected %0d %0h",
                                    i, obs_a[i], obs_d[i], exp_a[i], col);
                end
            end
            m_valid = 1'b1; m_x = cx; m_y = cy; m_col = col; m_size = s - 1;
            if (scramble) begin
                @(posedge clk); #1;
                bus.cursor_x = X_W'(cx);  bus.cursor_y = Y_W'(cy);
                bus.draw_colour = COLOUR_W'(col);  bus.brush_size = BRUSH_W'(sz);
                bus.draw_en = 1'b1;
            end
            repeat (5) begin
                @(negedge clk);
                vec++;
                if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0) begin
                    err++; $display("FAIL no_repeat: busy=%b we=%b expected 0 0", bus.busy, bus.ram_we);
                end
            end
        end
        bus.draw_en = 1'b0;
    endtask

    task automatic test_clear(input int col, input bit pen);
        int nw, bad, first_bad, pulses, last_cyc, done_cyc, restamp_cyc;
        bit busy_at_done;
        nw = 0; bad = 0; first_bad = -1; pulses = 0; last_cyc = -10; done_cyc = -1; restamp_cyc = -1;
        busy_at_done = 1'b1;
        @(posedge clk); #1;
        if (pen) begin
            bus.cursor_x = X_W'(m_x);  bus.cursor_y = Y_W'(m_y);
            bus.draw_colour = COLOUR_W'(m_col);  bus.brush_size = BRUSH_W'(m_size);
            bus.draw_en = 1'b1;
        end
        bus.clear_req = 1'b1;
        bus.clear_colour = COLOUR_W'(col);
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        bus.clear_colour = ~COLOUR_W'(col);
        for (int c = 0; c < PIX + 100; c++) begin
            @(negedge clk);
            if (bus.clear_done) begin
                pulses++;
                if (done_cyc < 0) begin done_cyc = c; busy_at_done = bus.busy; end
            end
            if (bus.ram_we && done_cyc < 0) begin
                if (int'(bus.ram_a) != nw || int'(bus.ram_wd) != col) begin
                    bad++;
                    if (first_bad < 0) first_bad = nw;
                end
                if (nw == PIX - 1) last_cyc = c;
                nw++;
            end
            if (done_cyc >= 0 && c > done_cyc && bus.busy && restamp_cyc < 0) restamp_cyc = c;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        vec++;
        if (nw != PIX) begin err++; $display("FAIL clear_count: %0d writes expected %0d", nw, PIX); end
        vec++;
        if (bad != 0) begin err++; $display("FAIL clear_data: %0d bad writes (first at %0d) expected 0", bad, first_bad); end
        vec++;
        if (pulses != 1) begin err++; $display("FAIL clear_done_pulses: %0d expected 1", pulses); end
        vec++;
        if (done_cyc != last_cyc + 1 || busy_at_done !== 1'b0) begin
            err++; $display("FAIL clear_done_timing: done at %0d busy=%b expected %0d busy=0", done_cyc, busy_at_done, last_cyc + 1);
        end
        if (pen) begin
            vec++;
            if (restamp_cyc != done_cyc + 1) begin
                err++; $display("FAIL clear_restamp: busy at %0d expected %0d", restamp_cyc, done_cyc + 1);
            end
            for (int c = 0; c < 100 && bus.busy; c++) @(negedge clk);
        end
        bus.draw_en = 1'b0;
        m_valid = pen;
    endtask

    task automatic test_clear_during_brush();
        int ccol, bw, gap, ph;
        bit req_sent, started, ok;
        ccol = $urandom_range(0, 4095);
        bw = 0; gap = 0; ph = 0; req_sent = 0; started = 0; ok = 0;
        @(posedge clk); #1;
        bus.cursor_x = X_W'(40);  bus.cursor_y = Y_W'(50);
        bus.draw_colour = COLOUR_W'($urandom);  bus.brush_size = BRUSH_W'(3);
        bus.draw_en = 1'b1;
        @(posedge clk); #1;
        bus.draw_en = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.clear_req) bus.clear_req = 1'b0;
            if (ph == 0) begin
                if (bus.busy) started = 1;
                if (bus.ram_we) bw++;
                if (bw == 3 && !req_sent) begin
                    bus.clear_req = 1'b1;
                    bus.clear_colour = COLOUR_W'(ccol);
                    req_sent = 1;
                end
                if (started && !bus.busy) begin ph = 1; gap = 1; end
            end else begin
                if (!bus.busy) gap++;
                else begin
                    vec++;
                    if (bus.ram_we !== 1'b1 || bus.ram_a !== '0 || int'(bus.ram_wd) != ccol) begin
                        err++; $display("FAIL clear_after_brush_first: we=%b a=%0d wd=%0h expected 1 0 %0h",
                                        bus.ram_we, bus.ram_a, bus.ram_wd, ccol);
                    end
                    ok = 1;
                    break;
                end
            end
        end
        vec++;
        if (!ok) begin err++; $display("FAIL clear_after_brush_timeout: clear never started, expected start"); end
        vec++;
        if (bw != 16) begin err++; $display("FAIL brush_before_clear: %0d writes expected 16", bw); end
        vec++;
        if (gap != 1) begin err++; $display("FAIL idle_gap: %0d idle cycles expected 1", gap); end
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        bit found, quiet;
        found = 0; quiet = 1;
        @(posedge clk); #1;
        bus.clear_req = 1'b1;
        bus.clear_colour = COLOUR_W'($urandom);
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.ram_we && bus.ram_a == ADDR_W'(100)) begin found = 1; break; end
        end
        vec++;
        if (!found) begin err++; $display("FAIL reset_clear_reach: addr 100 never written, expected written"); end
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        vec++;
        if (bus.ram_we !== 1'b0) begin err++; $display("FAIL reset_we_gate: ram_we=%b expected 0", bus.ram_we); end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        vec++;
        if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0) begin
            err++; $display("FAIL reset_abort: busy=%b we=%b expected 0 0", bus.busy, bus.ram_we);
        end
        repeat (300) begin
            @(negedge clk);
            if (bus.clear_done !== 1'b0 || bus.ram_we !== 1'b0 || bus.busy !== 1'b0) quiet = 0;
        end
        vec++;
        if (!quiet) begin err++; $display("FAIL reset_quiet: activity after abort, expected none"); end
        m_valid = 1'b0;
    endtask

    initial begin
        int cx, cy, sz, pa;
        test_reset();
        test_stamp(5, 3, 'hF00, 0, -1, 0, 1'b0);
        test_stamp(158, 119, $urandom_range(0, 4095), 2, -1, 0, 1'b1);
        test_stamp(20, 30, 'h5A5, 3, 5, 20, 1'b0);
        test_stamp(20, 30, 'h5A5, 3, -1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(150, 165);
            cy = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 127) : $urandom_range(110, 125);
            sz = $urandom_range(0, 3);
            pa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : -1;
            test_stamp(cx, cy, $urandom_range(0, 4095), sz, pa, $urandom_range(1, 8), $urandom_range(0, 1) == 1);
        end
        test_clear('h0AF, 1'b1);
        test_clear_during_brush();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
